// File: rtl/pe_pkg.sv
// Shared types, default widths and the saturating adder for the dual-mode PE.
package pe_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int SATURATE_DEF   = 1;

  // The adder works on a fixed 64-bit carrier, so ACC_WIDTH may be at most 62.
  // That keeps the exact ACC_WIDTH+1 bit sum free of overflow.
  localparam int SAT_CARRIER_W = 64;

  typedef enum logic {
    PE_MODE_WS = 1'b0,
    PE_MODE_OS = 1'b1
  } pe_mode_e;

  typedef struct packed {
    logic signed [SAT_CARRIER_W-1:0] sum;
    logic                            clamped;
  } sat_res_t;

  // Exact signed add, then optionally clamp to the signed range of 'width' bits.
  // With saturate=0 the caller truncates to 'width' bits, which gives a wrap.
  function automatic sat_res_t sat_add(input logic signed [SAT_CARRIER_W-1:0] a,
                                       input logic signed [SAT_CARRIER_W-1:0] b,
                                       input int                              width,
                                       input logic                            saturate);
    sat_res_t                        r;
    logic signed [SAT_CARRIER_W-1:0] s;
    logic signed [SAT_CARRIER_W-1:0] hi;
    logic signed [SAT_CARRIER_W-1:0] lo;
    s         = a + b;
    hi        = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo        = ~hi;
    r.sum     = s;
    r.clamped = 1'b0;
    if (saturate && (s > hi)) begin
      r.sum     = hi;
      r.clamped = 1'b1;
    end else if (saturate && (s < lo)) begin
      r.sum     = lo;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_dual_mode_weight_buf.sv
// Double-buffered stationary weight.
// The shadow register loads from the north chain while the active weight feeds the MAC.
module pe_weight_buf
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         weight_ld,
  input  logic                         weight_swap,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  output logic signed [DATA_WIDTH-1:0] active_o
);

  logic signed [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic signed [DATA_WIDTH-1:0] active_q, active_d;

  // Next state: a swap reads the old shadow, so ld+swap in one cycle moves the old value.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (weight_swap) active_d = shadow_q;
    if (weight_ld)   shadow_d = weight_in;
  end

  // Weight registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/pe_dual_mode.sv
// Dual-dataflow systolic processing element.
// WS mode cascades partial sums south.
// OS mode keeps a local accumulator and drains it through the acc_out shift chain.
module pe_dual_mode
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int SATURATE   = SATURATE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [DATA_WIDTH-1:0] weight_out,
  input  logic                  weight_ld,
  input  logic                  weight_swap,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  output logic [ACC_WIDTH-1:0]  acc_out,
  input  logic                  acc_clr,
  input  logic                  acc_ld,
  input  logic                  acc_shift,
  output logic                  sat_flag
);

  pe_mode_e mode_e;
  assign mode_e = pe_mode_e'(mode);

  logic signed [DATA_WIDTH-1:0] active_w;

  pe_weight_buf #(.DATA_WIDTH(DATA_WIDTH)) u_weight_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .weight_ld   (weight_ld),
    .weight_swap (weight_swap),
    .weight_in   ($signed(weight_in)),
    .active_o    (active_w)
  );

  // Full-precision products: WS uses the stationary weight, OS uses the streamed weight.
  logic signed [2*DATA_WIDTH-1:0] prod_ws, prod_os;
  assign prod_ws = $signed(data_in) * active_w;
  assign prod_os = $signed(data_in) * $signed(weight_in);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] weight_out_q, weight_out_d;
  logic [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
  logic [ACC_WIDTH-1:0]  acc_r_q, acc_r_d;
  logic                  sat_q, sat_d;

  sat_res_t ws_res, os_res;

  // Candidate sums for both dataflows, computed on the wide carrier.
  always_comb begin
    ws_res = sat_add(64'($signed(acc_in)), 64'(prod_ws), ACC_WIDTH, SATURATE != 0);
    os_res = sat_add(64'($signed(acc_r_q)), 64'(prod_os), ACC_WIDTH, SATURATE != 0);
  end

  // Only the low ACC_WIDTH bits of a sum are kept.
  logic unused_hi;
  assign unused_hi = ^{ws_res.sum[SAT_CARRIER_W-1:ACC_WIDTH],
                       os_res.sum[SAT_CARRIER_W-1:ACC_WIDTH]};

  // Next state for forwarding, the MAC, the OS accumulator, the drain and the sticky flag.
  always_comb begin
    logic clamp_evt;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    weight_out_d = weight_out_q;
    acc_out_d    = acc_out_q;
    acc_r_d      = acc_r_q;
    clamp_evt    = 1'b0;

    if (en) begin
      data_out_d   = data_in;
      data_valid_d = data_valid_in;
    end
    // The weight load chain must shift even while compute is stalled.
    if (en || weight_ld) weight_out_d = weight_in;

    if (mode_e == PE_MODE_WS) begin
      if (en) begin
        if (data_valid_in) begin
          acc_out_d = ws_res.sum[ACC_WIDTH-1:0];
          clamp_evt = ws_res.clamped;
        end else begin
          acc_out_d = acc_in;
        end
      end
    end else begin
      // The drain samples acc_r before this cycle's accumulate lands.
      if (acc_ld)         acc_out_d = acc_r_q;
      else if (acc_shift) acc_out_d = acc_in;

      if (acc_clr && en && data_valid_in) begin
        acc_r_d = ACC_WIDTH'(prod_os);
      end else if (acc_clr) begin
        acc_r_d = '0;
      end else if (en && data_valid_in) begin
        acc_r_d   = os_res.sum[ACC_WIDTH-1:0];
        clamp_evt = os_res.clamped;
      end
    end

    // acc_clr clears the flag in either mode; a clamp in the same cycle re-arms it.
    sat_d = (acc_clr ? 1'b0 : sat_q) | clamp_evt;
  end

  // Pipeline registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      weight_out_q <= '0;
      acc_out_q    <= '0;
      acc_r_q      <= '0;
      sat_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      weight_out_q <= weight_out_d;
      acc_out_q    <= acc_out_d;
      acc_r_q      <= acc_r_d;
      sat_q        <= sat_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid_out = data_valid_q;
  assign weight_out     = weight_out_q;
  assign acc_out        = acc_out_q;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_pe_dual_mode.sv
// Bench for pe_dual_mode.
// Two 16-bit instances share every input: one saturating, one wrapping.
module tb_pe_dual_mode;

  localparam int DW = 8;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          en, mode, data_valid_in, weight_ld, weight_swap, acc_clr, acc_ld, acc_shift;
  logic [DW-1:0] data_in, weight_in;
  logic [AW-1:0] acc_in;

  logic [DW-1:0] s_data_out, s_weight_out, w_data_out, w_weight_out;
  logic          s_dvo, s_sat, w_dvo, w_sat;
  logic [AW-1:0] s_acc_out, w_acc_out;

  pe_dual_mode #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .data_out(s_data_out), .data_valid_out(s_dvo),
    .weight_in(weight_in), .weight_out(s_weight_out),
    .weight_ld(weight_ld), .weight_swap(weight_swap),
    .acc_in(acc_in), .acc_out(s_acc_out),
    .acc_clr(acc_clr), .acc_ld(acc_ld), .acc_shift(acc_shift),
    .sat_flag(s_sat));

  pe_dual_mode #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .data_out(w_data_out), .data_valid_out(w_dvo),
    .weight_in(weight_in), .weight_out(w_weight_out),
    .weight_ld(weight_ld), .weight_swap(weight_swap),
    .acc_in(acc_in), .acc_out(w_acc_out),
    .acc_clr(acc_clr), .acc_ld(acc_ld), .acc_shift(acc_shift),
    .sat_flag(w_sat));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = saturating instance, 1 = wrapping instance.
  longint m_data_out, m_weight_out, m_shadow, m_active;
  bit     m_dvo;
  longint m_acc_out[2];
  longint m_acc_r[2];
  bit     m_sat[2];

  task automatic model_reset();
    m_data_out = 0; m_weight_out = 0; m_shadow = 0; m_active = 0; m_dvo = 0;
    for (int i = 0; i < 2; i++) begin
      m_acc_out[i] = 0; m_acc_r[i] = 0; m_sat[i] = 0;
    end
  endtask

  // Bring an exact sum into 16-bit signed range: clamp or wrap.
  function automatic longint fit(input longint s, input bit sat, output bit f);
    f = 0;
    if (sat) begin
      if (s > 32767)  begin f = 1; return 32767;  end
      if (s < -32768) begin f = 1; return -32768; end
      return s;
    end
    return ((s % 65536) + 65536 + 32768) % 65536 - 32768;
  endfunction

  // One clock: compute the expected post-edge state from the current inputs, then commit it at the edge.
  task automatic tick();
    longint d, w, a, n_do, n_wo, n_sh, n_ac;
    longint n_acc_out[2];
    longint n_acc_r[2];
    bit     n_sat[2];
    bit     n_dv, f;
    d = longint'($signed(data_in));
    w = longint'($signed(weight_in));
    a = longint'($signed(acc_in));
    n_do = m_data_out; n_dv = m_dvo; n_wo = m_weight_out; n_sh = m_shadow; n_ac = m_active;
    if (en) begin n_do = d; n_dv = data_valid_in; end
    if (en || weight_ld) n_wo = w;
    if (weight_swap) n_ac = m_shadow;
    if (weight_ld)   n_sh = w;
    for (int i = 0; i < 2; i++) begin
      n_acc_out[i] = m_acc_out[i];
      n_acc_r[i]   = m_acc_r[i];
      f = 0;
      if (!mode) begin
        if (en && data_valid_in) n_acc_out[i] = fit(a + d * m_active, i == 0, f);
        else if (en)             n_acc_out[i] = a;
      end else begin
        if (acc_ld)         n_acc_out[i] = m_acc_r[i];
        else if (acc_shift) n_acc_out[i] = a;
        if (acc_clr && en && data_valid_in) n_acc_r[i] = d * w;
        else if (acc_clr)                   n_acc_r[i] = 0;
        else if (en && data_valid_in)       n_acc_r[i] = fit(m_acc_r[i] + d * w, i == 0, f);
      end
      n_sat[i] = (acc_clr ? 1'b0 : m_sat[i]) | f;
    end
    @(posedge clk);
    m_data_out = n_do; m_dvo = n_dv; m_weight_out = n_wo; m_shadow = n_sh; m_active = n_ac;
    for (int i = 0; i < 2; i++) begin
      m_acc_out[i] = n_acc_out[i]; m_acc_r[i] = n_acc_r[i]; m_sat[i] = n_sat[i];
    end
    @(negedge clk);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("s_data_out",   $signed(s_data_out),   m_data_out);
      check("s_dvo",        s_dvo,                 m_dvo);
      check("s_weight_out", $signed(s_weight_out), m_weight_out);
      check("s_acc_out",    $signed(s_acc_out),    m_acc_out[0]);
      check("s_sat",        s_sat,                 m_sat[0]);
      check("w_data_out",   $signed(w_data_out),   m_data_out);
      check("w_dvo",        w_dvo,                 m_dvo);
      check("w_weight_out", $signed(w_weight_out), m_weight_out);
      check("w_acc_out",    $signed(w_acc_out),    m_acc_out[1]);
      check("w_sat",        w_sat,                 m_sat[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    en = 0; mode = 0; data_valid_in = 0; weight_ld = 0; weight_swap = 0;
    acc_clr = 0; acc_ld = 0; acc_shift = 0;
    data_in = '0; weight_in = '0; acc_in = '0;
  endtask

  task automatic load_swap(input int wv);
    en = 0; data_valid_in = 0;
    weight_in = 8'(wv); weight_ld = 1; tick();
    weight_ld = 0; weight_swap = 1; tick();
    weight_swap = 0;
  endtask

  task automatic ws_mac(input int d, input int a);
    mode = 0; en = 1; data_valid_in = 1;
    data_in = 8'(d); acc_in = 16'(a); tick();
  endtask

  task automatic os_mac(input int d, input int w, input bit clr);
    mode = 1; en = 1; data_valid_in = 1; acc_clr = clr;
    data_in = 8'(d); weight_in = 8'(w); tick();
    acc_clr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_acc"}, $signed(s_acc_out), 0);
    check({tag, "_w_acc"}, $signed(w_acc_out), 0);
    check({tag, "_data"},  $signed(s_data_out), 0);
    check({tag, "_dvo"},   s_dvo, 0);
    check({tag, "_wout"},  $signed(s_weight_out), 0);
    check({tag, "_sat"},   s_sat, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1;
    chk_on = 1;

    // WS basic: weight 3, data -4, acc_in 100 -> 88.
    load_swap(3);
    ws_mac(-4, 100);
    check("ws_basic_acc",  $signed(s_acc_out), 88);
    check("ws_basic_data", $signed(s_data_out), -4);
    check("ws_basic_dvo",  s_dvo, 1);

    // Swap race: shadow 5, then ld 7 with swap -> active 5.
    en = 0; data_valid_in = 0;
    weight_in = 8'(5); weight_ld = 1; tick();
    weight_in = 8'(7); weight_ld = 1; weight_swap = 1; tick();
    weight_ld = 0; weight_swap = 0;
    ws_mac(2, 0);
    check("swap_race_acc", $signed(s_acc_out), 10);
    en = 0; weight_swap = 1; tick(); weight_swap = 0;
    ws_mac(1, 0);
    check("swap_shadow_acc", $signed(s_acc_out), 7);

    // Extreme products.
    load_swap(127);
    ws_mac(-128, 0);
    check("prod_min_max", $signed(s_acc_out), -16256);
    load_swap(-128);
    ws_mac(-128, 0);
    check("prod_min_min", $signed(s_acc_out), 16384);

    // Saturation vs wrap: 32700 + 16384.
    ws_mac(-128, 32700);
    check("sat_acc",  $signed(s_acc_out), 32767);
    check("sat_flag", s_sat, 1);
    check("wrap_acc", $signed(w_acc_out), -16452);
    check("wrap_flag", w_sat, 0);

    // Bubble, then a stall with the weight chain still shifting.
    en = 1; data_valid_in = 0; acc_in = 16'(1234); tick();
    check("bubble_acc", $signed(s_acc_out), 1234);
    check("sat_sticky", s_sat, 1);
    en = 0; weight_ld = 1;
    for (int k = 1; k <= 3; k++) begin
      weight_in = 8'(11 * k); data_in = 8'(k); acc_in = 16'(k); data_valid_in = 1; tick();
    end
    weight_ld = 0; data_valid_in = 0;
    check("stall_wout", $signed(s_weight_out), 33);
    check("stall_acc",  $signed(s_acc_out), 1234);
    check("stall_data", $signed(s_data_out), -128);
    acc_clr = 1; tick(); acc_clr = 0;
    check("clr_flag", s_sat, 0);
    check("clr_ws_acc_hold", $signed(s_acc_out), 1234);

    // OS accumulate (2,3),(-1,4),(5,5) -> 27, then drain.
    os_mac(2, 3, 1);
    os_mac(-1, 4, 0);
    os_mac(5, 5, 0);
    en = 0; data_valid_in = 0; acc_ld = 1; tick(); acc_ld = 0;
    check("os_ld", $signed(s_acc_out), 27);
    acc_shift = 1; acc_in = 16'(9); tick(); acc_shift = 0;
    check("os_shift", $signed(s_acc_out), 9);
    acc_ld = 1; os_mac(1, 1, 0); acc_ld = 0;
    check("os_ld_pre_update", $signed(s_acc_out), 27);
    en = 0; data_valid_in = 0; acc_ld = 1; tick(); acc_ld = 0;
    check("os_ld_post_update", $signed(s_acc_out), 28);

    // Asynchronous reset in the middle of a drain shift.
    mode = 1; en = 0; acc_shift = 1; acc_in = 16'(77);
    #2 rst_n = 0;
    model_reset();
    #1 check_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; acc_shift = 0;
    os_mac(4, 5, 0);
    en = 0; data_valid_in = 0; acc_ld = 1; tick(); acc_ld = 0;
    check("post_rst_acc", $signed(s_acc_out), 20);

    idle_inputs();
    repeat (2) tick();
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
